// File: rtl/gpr_bank.sv
// Multi-ported general-purpose register bank: two write ports, three combinational
// read ports, and a sequential zero-fill of the array after every reset.
module gpr_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA0,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    input  logic [ADDR_W-1:0] RA0,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD0,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              READY
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic clr_en;
    logic wr0_en;
    logic wr1_en;

    // A reset edge must never touch the array, so every write path is gated by RST.
    assign clr_en = (state_q == ST_CLEAR) && !RST;
    assign wr0_en = (state_q == ST_RUN) && !RST && WE0;
    assign wr1_en = (state_q == ST_RUN) && !RST && WE1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [DATA_W-1:0] word_d;
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign word_d = '0;
            end else begin : g_rw
                // Port 1 is checked first so it wins an address collision.
                always_comb begin
                    word_d = mem_q[gi];
                    if (clr_en && ptr_q == ADDR_W'(gi)) begin
                        word_d = '0;
                    end else if (wr1_en && WA1 == ADDR_W'(gi)) begin
                        word_d = WD1;
                    end else if (wr0_en && WA0 == ADDR_W'(gi)) begin
                        word_d = WD0;
                    end
                end
            end
            always_ff @(posedge CLK) begin
                mem_q[gi] <= word_d;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] ra [3];
    logic [DATA_W-1:0] rd [3];

    assign ra[0] = RA0;
    assign ra[1] = RA1;
    assign ra[2] = RA2;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd[p] = '0;
            if (state_q == ST_RUN) begin
                if (ZERO_REG != 0 && ra[p] == '0) begin
                    rd[p] = '0;
                end else if (BYPASS != 0 && wr1_en && WA1 == ra[p]) begin
                    rd[p] = WD1;
                end else if (BYPASS != 0 && wr0_en && WA0 == ra[p]) begin
                    rd[p] = WD0;
                end else begin
                    rd[p] = mem_q[ra[p]];
                end
            end
        end
    end

    assign RD0   = rd[0];
    assign RD1   = rd[1];
    assign RD2   = rd[2];
    assign READY = ready_q;

endmodule
